// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
// Both the transmit and the receive side decode the same three-state protocol.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2
  } cdc_hs_state_e;

endpackage : cdc_pkg

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchronizer; metastability is confined to the first flop.
// RST_VAL lets the caller choose which level the chain holds during reset.
module sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_r[SYNC_STAGES-1];

endmodule : sync_ff

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack handshake: captures one local word and
// presents it with a level request until the foreign side completes the cycle.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ack,
  output logic              o_err
);

  cdc_hs_state_e     state_r;
  cdc_hs_state_e     state_nxt_s;
  logic              req_r;
  logic              req_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic              load_s;
  logic              err_r;
  logic              err_nxt_s;
  logic              ack_s;

  // Chain resets high so a stale acknowledge is assumed until proven low.
  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ack),
    .o_q     (ack_s)
  );

  // Next-state, request level and capture decode.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          state_nxt_s = ST_REQ_HI;
          req_nxt_s   = 1'b1;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          state_nxt_s = ST_REQ_LO;
          req_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_REQ_HI;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ_LO;
        end
      end
      default: begin
        state_nxt_s = ST_REQ_LO;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // A synchronized acknowledge while idle can only be spurious.
  always_comb begin
    err_nxt_s = err_r | ((state_r == ST_IDLE) & ack_s);
  end

  // Reset parks in ST_REQ_LO so a launch waits for a clean low acknowledge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_REQ_LO;
      req_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Payload holds the last accepted word; it is never cleared between transfers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      data_r <= i_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign o_ready = (state_r == ST_IDLE);
  assign o_req   = req_r;
  assign o_data  = data_r;
  assign o_err   = err_r;

endmodule : cdc_hs_tx

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with hand-computed cycle-by-cycle expectations.
module tb_cdc_hs_tx;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       o_req;
  logic [7:0] o_data;
  logic       i_ack;
  logic       o_err;

  int n_checks;
  int n_fails;
  bit loop_en;

  cdc_hs_tx #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_req   (o_req),
    .o_data  (o_data),
    .i_ack   (i_ack),
    .o_err   (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; loopback ack follows o_req shortly after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (loop_en) i_ack = o_req;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    loop_en  = 1'b0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_data   = 8'h00;
    i_ack    = 1'b0;

    // Reset release with i_ack low: ready only after edge 3.
    #22;
    check_eq("rst_req", {31'd0, o_req}, 32'd0);
    check_eq("rst_ready", {31'd0, o_ready}, 32'd0);
    i_rst_n = 1'b1;
    tick();
    check_eq("rel_e1_ready", {31'd0, o_ready}, 32'd0);
    tick();
    check_eq("rel_e2_ready", {31'd0, o_ready}, 32'd0);
    tick();
    check_eq("rel_e3_ready", {31'd0, o_ready}, 32'd1);
    check_eq("rel_data", {24'd0, o_data}, 32'h00);
    check_eq("rel_req", {31'd0, o_req}, 32'd0);
    check_eq("rel_err", {31'd0, o_err}, 32'd0);

    // Loopback, valid held: accepts at E0 and E7.
    loop_en = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick();  // E0
    check_eq("lb_e0_req", {31'd0, o_req}, 32'd1);
    check_eq("lb_e0_data", {24'd0, o_data}, 32'hA5);
    check_eq("lb_e0_ready", {31'd0, o_ready}, 32'd0);
    i_data = 8'hFF;  // ignored while in ST_REQ_HI
    tick();  // E1
    check_eq("noc_e1_data", {24'd0, o_data}, 32'hA5);
    i_data = 8'h3C;
    tick();  // E2
    check_eq("lb_e2_req", {31'd0, o_req}, 32'd1);
    tick();  // E3
    check_eq("lb_e3_req", {31'd0, o_req}, 32'd0);
    ticks(2);  // E5
    check_eq("lb_e5_ready", {31'd0, o_ready}, 32'd0);
    tick();  // E6
    check_eq("lb_e6_ready", {31'd0, o_ready}, 32'd1);
    check_eq("lb_e6_data", {24'd0, o_data}, 32'hA5);
    tick();  // E7
    check_eq("lb_e7_data", {24'd0, o_data}, 32'h3C);
    check_eq("lb_e7_req", {31'd0, o_req}, 32'd1);
    i_valid = 1'b0;
    ticks(6);  // second transfer done at E13
    check_eq("lb_e13_ready", {31'd0, o_ready}, 32'd1);
    check_eq("lb_err", {31'd0, o_err}, 32'd0);
    loop_en = 1'b0;

    // Delayed ack: i_ack high for sampling at E10, req falls after E12.
    begin
      int req_hi_cnt;
      int ready_wait;
      req_hi_cnt = 0;
      i_valid = 1'b1;
      i_data  = 8'h5A;
      tick();  // E0
      i_valid = 1'b0;
      check_eq("dly_e0_data", {24'd0, o_data}, 32'h5A);
      for (int c = 1; c <= 20; c++) begin
        if (o_req) req_hi_cnt++;
        if (c == 10) i_ack = 1'b1;
        tick();
        if (!o_req && i_ack) i_ack = 1'b0;
        if (c == 12) check_eq("dly_e12_req", {31'd0, o_req}, 32'd0);
        if (c == 13) check_eq("dly_e13_ready", {31'd0, o_ready}, 32'd0);
        if (c == 14) check_eq("dly_e14_ready", {31'd0, o_ready}, 32'd0);
        if (c == 15) check_eq("dly_e15_ready", {31'd0, o_ready}, 32'd1);
      end
      check_eq("dly_req_cycles", req_hi_cnt, 32'd12);
      ready_wait = 0;
      while (!o_ready && ready_wait < 50) begin
        tick();
        ready_wait++;
      end
      check_eq("dly_ready_timeout", {31'd0, o_ready}, 32'd1);
    end

    // Spurious ack in idle sets a sticky error.
    check_eq("err_pre", {31'd0, o_err}, 32'd0);
    i_ack = 1'b1;
    ticks(3);
    check_eq("err_set", {31'd0, o_err}, 32'd1);
    check_eq("err_idle_kept", {31'd0, o_ready}, 32'd1);
    i_ack = 1'b0;
    ticks(3);
    check_eq("err_sticky", {31'd0, o_err}, 32'd1);
    check_eq("err_ready", {31'd0, o_ready}, 32'd1);

    // Reset in ST_REQ_HI with ack high: req drops at once, ready waits on ack.
    i_valid = 1'b1;
    i_data  = 8'hC3;
    tick();
    i_valid = 1'b0;
    i_ack   = 1'b1;
    tick();
    check_eq("mrst_pre_req", {31'd0, o_req}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("mrst_req", {31'd0, o_req}, 32'd0);
    check_eq("mrst_err", {31'd0, o_err}, 32'd0);
    check_eq("mrst_data", {24'd0, o_data}, 32'h00);
    #3;
    i_rst_n = 1'b1;
    ticks(5);
    check_eq("mrst_ack_hi_ready", {31'd0, o_ready}, 32'd0);
    i_ack = 1'b0;
    tick();
    check_eq("mrst_d1_ready", {31'd0, o_ready}, 32'd0);
    tick();
    check_eq("mrst_d2_ready", {31'd0, o_ready}, 32'd0);
    tick();
    check_eq("mrst_d3_ready", {31'd0, o_ready}, 32'd1);
    check_eq("mrst_end_err", {31'd0, o_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_cdc_hs_tx
